// File: rtl/alu_op_sequencer.sv
// Command sequencer that drives a combinational NZCV ALU for COUNT passes. After each pass
// the ALU result is fed back as operand A, and carry/overflow are accumulated across passes.
module alu_op_sequencer #(
  parameter int BITS  = 5,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [BITS-1:0]  cmd_a,
  input  logic [BITS-1:0]  cmd_b,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [BITS-1:0]  alu_in_a,
  output logic [BITS-1:0]  alu_in_b,
  output logic [1:0]       alu_ctrl,
  input  logic [BITS-1:0]  alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [BITS-1:0]  rsp_result,
  output logic [3:0]       rsp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [BITS-1:0]   in_a_q, in_a_d;
  logic [BITS-1:0]   in_b_q, in_b_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              sticky_c_q, sticky_c_d;
  logic              sticky_v_q, sticky_v_d;
  logic [BITS-1:0]   rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_a_q       <= '0;
      in_b_q       <= '0;
      ctrl_q       <= 2'b00;
      rem_q        <= '0;
      sticky_c_q   <= 1'b0;
      sticky_v_q   <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
    end else begin
      state_q      <= state_d;
      in_a_q       <= in_a_d;
      in_b_q       <= in_b_d;
      ctrl_q       <= ctrl_d;
      rem_q        <= rem_d;
      sticky_c_q   <= sticky_c_d;
      sticky_v_q   <= sticky_v_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    in_a_d       = in_a_q;
    in_b_d       = in_b_q;
    ctrl_d       = ctrl_q;
    rem_d        = rem_q;
    sticky_c_d   = sticky_c_q;
    sticky_v_d   = sticky_v_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          in_a_d     = cmd_a;
          in_b_d     = cmd_b;
          ctrl_d     = cmd_op;
          rem_d      = (cmd_count == '0) ? CNT_ONE : cmd_count;
          sticky_c_d = 1'b0;
          sticky_v_d = 1'b0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        // The ALU output has settled by the edge, so each cycle is one complete pass.
        sticky_c_d = sticky_c_q | alu_flags[1];
        sticky_v_d = sticky_v_q | alu_flags[0];
        rem_d      = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) begin
          rsp_result_d = alu_result;
          rsp_flags_d  = {alu_flags[3:2], sticky_c_q | alu_flags[1], sticky_v_q | alu_flags[0]};
          state_d      = DONE;
        end else begin
          in_a_d = alu_result;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign alu_in_a   = in_a_q;
  assign alu_in_b   = in_b_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer, with a reference NZCV ALU closing the loop.
module tb_alu_op_sequencer;

  localparam int BITS  = 5;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [BITS-1:0]  cmd_a;
  logic [BITS-1:0]  cmd_b;
  logic [CNT_W-1:0] cmd_count;
  logic [BITS-1:0]  alu_in_a;
  logic [BITS-1:0]  alu_in_b;
  logic [1:0]       alu_ctrl;
  logic [BITS-1:0]  alu_result;
  logic [3:0]       alu_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [BITS-1:0]  rsp_result;
  logic [3:0]       rsp_flags;

  alu_op_sequencer #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_count(cmd_count),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [BITS-1:0] res;
    logic [3:0]      flg;
    int              acc;
    int              n;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference ALU: {N,Z,C,V,result}; SUB carry means "no borrow".
  function automatic logic [BITS+3:0] alu_ref(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                               input logic [1:0] op);
    logic [BITS:0]   w;
    logic [BITS-1:0] r;
    logic            c, v;
    c = 1'b0;
    v = 1'b0;
    w = '0;
    case (op)
      2'b00: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[BITS-1:0];
        c = w[BITS];
        v = (a[BITS-1] == b[BITS-1]) && (r[BITS-1] != a[BITS-1]);
      end
      2'b01: begin
        w = {1'b0, a} + {1'b0, ~b} + (BITS+1)'(1);
        r = w[BITS-1:0];
        c = w[BITS];
        v = (a[BITS-1] != b[BITS-1]) && (r[BITS-1] != a[BITS-1]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r[BITS-1], (r == '0), c, v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_ref(alu_in_a, alu_in_b, alu_ctrl);

  function automatic logic [BITS+3:0] model_seq(input logic [1:0] op, input logic [BITS-1:0] a,
                                                 input logic [BITS-1:0] b, input int n);
    logic [BITS+3:0] o;
    logic [BITS-1:0] acc;
    logic            sc, sv;
    acc = a;
    sc  = 1'b0;
    sv  = 1'b0;
    o   = '0;
    for (int i = 0; i < n; i++) begin
      o   = alu_ref(acc, b, op);
      sc  = sc | o[BITS+1];
      sv  = sv | o[BITS];
      acc = o[BITS-1:0];
    end
    return {o[BITS+3:BITS+2], sc, sv, acc};
  endfunction

  task automatic send(input logic [1:0] op, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                      input logic [CNT_W-1:0] cnt, input bit use_exp,
                      input logic [BITS-1:0] xres, input logic [3:0] xflg);
    exp_t            e;
    logic [BITS+3:0] m;
    bit              ok;
    e.n = (cnt == '0) ? 1 : int'(cnt);
    if (use_exp) begin
      e.res = xres;
      e.flg = xflg;
    end else begin
      m     = model_seq(op, a, b, e.n);
      e.res = m[BITS-1:0];
      e.flg = m[BITS+3:BITS];
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_count = cnt;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        e.acc = cyc + 1;
        sbq.push_back(e);
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) check("cmd_accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && cmd_ready) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'(0), 32'(1));
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  initial begin : monitor
    exp_t e;
    bit   pv;
    int   rise;
    pv   = 1'b0;
    rise = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (rsp_valid && !pv) rise = cyc;
        pv = rsp_valid;
        if (rsp_valid && rsp_ready) begin
          check("rsp_expected", 32'(sbq.size() != 0), 32'(1));
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_flags", 32'(rsp_flags), 32'(e.flg));
            check("rsp_latency", 32'(rise - e.acc), 32'(e.n));
          end
        end
      end
    end
  end

  initial begin : main
    bit seen;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_count = '0;
    rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_alu_in_a", 32'(alu_in_a), 32'(0));
    check("rst_alu_in_b", 32'(alu_in_b), 32'(0));
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'(0));
    check("rst_rsp_result", 32'(rsp_result), 32'(0));
    check("rst_rsp_flags", 32'(rsp_flags), 32'(0));
    rst_n = 1'b1;

    send(2'b00, 5'd3, 5'd4, 4'd1, 1'b1, 5'b00111, 4'b0000);
    send(2'b00, 5'd3, 5'd3, 4'd4, 1'b1, 5'b01111, 4'b0000);
    send(2'b00, 5'd7, 5'd5, 4'd2, 1'b1, 5'b10001, 4'b1001);
    send(2'b01, 5'd4, 5'd4, 4'd0, 1'b1, 5'b00000, 4'b0110);
    // 15 passes of +3 from 0: wraps once (sticky C) and crosses 15->18 (sticky V).
    send(2'b00, 5'd0, 5'd3, 4'd15, 1'b1, 5'd13, 4'b0011);
    send(2'b01, 5'd2, 5'd5, 4'd1, 1'b1, 5'd29, 4'b1000);
    send(2'b10, 5'b10110, 5'b01100, 4'd3, 1'b1, 5'b00100, 4'b0000);
    send(2'b11, 5'b10001, 5'b00110, 4'd2, 1'b1, 5'b10111, 4'b1000);
    for (int i = 0; i < 10; i++)
      send(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 4'($urandom), 1'b0, '0, '0);
    drain();

    // Back-pressure: response must hold and no command may slip in.
    rsp_ready = 1'b0;
    send(2'b00, 5'd1, 5'd2, 4'd1, 1'b1, 5'd3, 4'b0000);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("hold_rsp_seen", 32'(seen), 32'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_a     = 5'd9;
      cmd_b     = 5'd9;
      cmd_count = 4'd1;
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'(1));
      check("hold_rsp_result", 32'(rsp_result), 32'(3));
      check("hold_rsp_flags", 32'(rsp_flags), 32'(0));
      check("hold_cmd_ready", 32'(cmd_ready), 32'(0));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_cmd_ready", 32'(cmd_ready), 32'(1));
    check("release_rsp_valid", 32'(rsp_valid), 32'(0));
    send(2'b00, 5'd5, 5'd1, 4'd3, 1'b1, 5'd8, 4'b0000);
    drain();

    // Abort: reset in the middle of an 8-pass command.
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_a     = 5'd1;
    cmd_b     = 5'd1;
    cmd_count = 4'd8;
    @(negedge clk);
    check("abort_accept_ready", 32'(cmd_ready), 32'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_in_exec", 32'(cmd_ready), 32'(0));
    rst_n = 1'b0;
    #1;
    check("abort_cmd_ready", 32'(cmd_ready), 32'(1));
    check("abort_rsp_valid", 32'(rsp_valid), 32'(0));
    check("abort_alu_in_a", 32'(alu_in_a), 32'(0));
    check("abort_alu_in_b", 32'(alu_in_b), 32'(0));
    check("abort_alu_ctrl", 32'(alu_ctrl), 32'(0));
    check("abort_rsp_result", 32'(rsp_result), 32'(0));
    check("abort_rsp_flags", 32'(rsp_flags), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'(0));
      check("abort_idle_ready", 32'(cmd_ready), 32'(1));
    end

    send(2'b01, 5'd10, 5'd3, 4'd2, 1'b0, '0, '0);
    drain();
    check("sb_empty_end", 32'(sbq.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
